// File: rtl/exotiny_sim_pkg.sv
// rtl/exotiny_sim_pkg.sv - shared types and pattern helpers for the ExoTiny simulation models
package exotiny_sim_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP    = 2'd0,
        MODE_CONST_A = 2'd1,
        MODE_CONST_B = 2'd2,
        MODE_FIFO    = 2'd3
    } spiresp_mode_e;

    // Widest word the pattern helpers can produce; callers slice what they need.
    localparam int PAT_MAX_W = 64;

    // 'hAA-style pattern (odd bits set) for the low w bits.
    function automatic logic [PAT_MAX_W-1:0] pattern_aa(input int w);
        logic [PAT_MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < PAT_MAX_W; i++) begin
            if (i < w) p[i] = (i % 2) == 1;
        end
        return p;
    endfunction

    // 'h55-style pattern (even bits set) for the low w bits.
    function automatic logic [PAT_MAX_W-1:0] pattern_55(input int w);
        logic [PAT_MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < PAT_MAX_W; i++) begin
            if (i < w) p[i] = (i % 2) == 0;
        end
        return p;
    endfunction

endpackage

// File: rtl/exotiny_sync_fifo.sv
// rtl/exotiny_sync_fifo.sv - single-clock valid/ready FIFO with wrap-bit occupancy tracking
module exotiny_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // Same index with differing wrap bits means every slot is occupied.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s_tready = !full;
    assign m_tvalid = !empty;
    assign push     = s_tvalid && !full;
    assign pop      = m_tready && !empty;
    // Head reads as zero while empty so stale storage never leaks out.
    assign m_tdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
    end

endmodule

// File: rtl/exotiny_spi_responder.sv
// rtl/exotiny_spi_responder.sv - clocked SPI target model; RX capture enabled by EXOTINY_SPIRESP_RX_EN
module exotiny_spi_responder
    import exotiny_sim_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 16,
    parameter int               GPICNT   = 6,
    parameter int               IDLE_CYC = 64,
    parameter logic [WIDTH-1:0] FILL     = 'hFF
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic [1:0]        mode_i,
    input  logic              spi_sck_i,
    input  logic              spi_sdo_i,
    output logic              spi_sdi_o,
    output logic [GPICNT-1:0] gpi_o,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [WIDTH-1:0]  tx_data_i,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic [WIDTH-1:0]  rx_data_o,
    output logic [15:0]       frame_cnt_o,
    output logic              ovf_o,
    output logic              unf_o
);

    localparam int BCW = $clog2(WIDTH);
    localparam int ICW = $clog2(IDLE_CYC);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0] BIT_ONE  = 1;
    localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_CYC - 1);
    localparam logic [ICW-1:0] IDLE_ONE = 1;

    localparam logic [PAT_MAX_W-1:0] TX_AA_FULL  = pattern_aa(WIDTH);
    localparam logic [PAT_MAX_W-1:0] TX_55_FULL  = pattern_55(WIDTH);
    localparam logic [PAT_MAX_W-1:0] GPI_AA_FULL = pattern_aa(GPICNT);
    localparam logic [PAT_MAX_W-1:0] GPI_55_FULL = pattern_55(GPICNT);
    localparam logic [WIDTH-1:0]     TX_AA       = TX_AA_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     TX_55       = TX_55_FULL[WIDTH-1:0];
    localparam logic [GPICNT-1:0]    GPI_AA      = GPI_AA_FULL[GPICNT-1:0];
    localparam logic [GPICNT-1:0]    GPI_55      = GPI_55_FULL[GPICNT-1:0];

    spiresp_mode_e     mode;
    spiresp_mode_e     mode_q;
    logic              sck_q;
    logic              rise;
    logic              fall;
    logic              sck_edge;
    logic [BCW-1:0]    bit_cnt;
    logic [ICW-1:0]    idle_cnt;
    logic              idle_hit;
    logic              mode_chg;
    logic              abort;
    logic              first_rise;
    logic              frame_done;
    logic [WIDTH-2:0]  rx_sr;
    logic [WIDTH-1:0]  rx_word;
    logic [15:0]       frame_cnt;
    logic [WIDTH-1:0]  tx_sr;
    logic [WIDTH-1:0]  tx_sr_next;
    logic [WIDTH-1:0]  reload_val;
    logic              sdi_q;
    logic [GPICNT-1:0] gpi_q;
    logic              unf_q;
    logic              tx_head_valid;
    logic [WIDTH-1:0]  tx_head;
    logic              tx_pop;

    assign mode       = spiresp_mode_e'(mode_i);
    assign rise       = spi_sck_i && !sck_q;
    assign fall       = !spi_sck_i && sck_q;
    assign sck_edge   = rise || fall;
    assign idle_hit   = !sck_edge && (idle_cnt == IDLE_MAX);
    assign mode_chg   = (mode != mode_q);
    // A mode switch or a stalled controller both drop the partial frame.
    assign abort      = mode_chg || idle_hit;
    assign first_rise = rise && (bit_cnt == '0) && !abort;
    assign frame_done = rise && (bit_cnt == LAST_BIT) && !abort;
    assign rx_word    = {rx_sr, spi_sdo_i};
    assign tx_pop     = first_rise && (mode == MODE_FIFO) && tx_head_valid;

    // Edge history, bit counter, idle resync and completed-frame counter.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            sck_q     <= 1'b0;
            mode_q    <= MODE_LOOP;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            rx_sr     <= '0;
            frame_cnt <= '0;
        end else begin
            sck_q  <= spi_sck_i;
            mode_q <= mode;
            if (sck_edge)      idle_cnt <= '0;
            else if (!idle_hit) idle_cnt <= idle_cnt + IDLE_ONE;
            if (rise && !abort) rx_sr <= rx_word[WIDTH-2:0];
            if (abort)          bit_cnt <= '0;
            else if (rise)      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_ONE;
            if (frame_done)     frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Word presented between frames for the current mode.
    always_comb begin
        reload_val = FILL;
        case (mode)
            MODE_CONST_A: reload_val = TX_AA;
            MODE_CONST_B: reload_val = TX_55;
            MODE_FIFO:    reload_val = tx_head_valid ? tx_head : FILL;
            default:      reload_val = FILL;
        endcase
    end

    // Reload while idle between frames, shift on falling SCK inside a frame.
    always_comb begin
        tx_sr_next = tx_sr;
        if ((bit_cnt == '0) && !rise) tx_sr_next = reload_val;
        else if (fall && (bit_cnt != '0)) tx_sr_next = {tx_sr[WIDTH-2:0], 1'b0};
    end

    // TX shifter, registered MISO bit, GPI stimulus and underflow flag.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            tx_sr <= FILL;
            sdi_q <= 1'b0;
            gpi_q <= '0;
            unf_q <= 1'b0;
        end else begin
            tx_sr <= tx_sr_next;
            sdi_q <= tx_sr_next[WIDTH-1];
            case (mode)
                MODE_CONST_A: gpi_q <= GPI_AA;
                MODE_CONST_B: gpi_q <= GPI_55;
                default:      gpi_q <= '0;
            endcase
            if (first_rise && (mode == MODE_FIFO) && !tx_head_valid) unf_q <= 1'b1;
        end
    end

    exotiny_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk      (clk_i),
        .rst_n    (rst_in),
        .s_tvalid (tx_valid_i),
        .s_tready (tx_ready_o),
        .s_tdata  (tx_data_i),
        .m_tvalid (tx_head_valid),
        .m_tready (tx_pop),
        .m_tdata  (tx_head)
    );

    // Loopback bypasses the shifter entirely so MOSI reaches MISO with no delay.
    assign spi_sdi_o   = (mode == MODE_LOOP) ? spi_sdo_i : sdi_q;
    assign gpi_o       = gpi_q;
    assign frame_cnt_o = frame_cnt;
    assign unf_o       = unf_q;

`ifdef EXOTINY_SPIRESP_RX_EN
    logic rx_in_ready;
    logic ovf_q;

    exotiny_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk      (clk_i),
        .rst_n    (rst_in),
        .s_tvalid (frame_done),
        .s_tready (rx_in_ready),
        .s_tdata  (rx_word),
        .m_tvalid (rx_valid_o),
        .m_tready (rx_ready_i),
        .m_tdata  (rx_data_o)
    );

    // Sticky flag for a completed frame that found the RX FIFO full.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in)                        ovf_q <= 1'b0;
        else if (frame_done && !rx_in_ready) ovf_q <= 1'b1;
    end

    assign ovf_o = ovf_q;
`else
    logic unused_rx;

    assign unused_rx  = ^{rx_ready_i, rx_word};
    assign rx_valid_o = 1'b0;
    assign rx_data_o  = '0;
    assign ovf_o      = 1'b0;
`endif

endmodule
